hazard_stall_controller: RTL and testbench

- Sequences pipeline-register enables, flushes and bubbles for the 5-stage pipeline: load-use stalls, multicycle EX operations (mul/div), taken-branch flushes and data-memory wait states.
- Sits beside the forwarding unit and covers the hazards that forwarding cannot resolve.
- Drives the PC, IF/ID, ID/EX and EX/MEM register controls.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/stall_counter.sv | 28 ++
 rtl/hazard_stall_controller.sv | 150 +++++++++++++++
 tb/tb_hazard_stall_controller.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall controller slice.
package hazard_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        MC_BUSY
    } hz_state_t;

endpackage

// File: rtl/stall_counter.sv
// Loadable down-counter: load wins over dec, otherwise the value holds.
module stall_counter
    import hazard_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush sequencer for load-use, multicycle EX, taken branches and dmem waits.
// Optional perf counters are enabled with `define HAZARD_PERF_EN.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MC_LATENCY        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    input  logic              ex_mc_start,
    input  logic              mem_access,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_bubble,
    output logic              busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events,
    output logic [31:0]       freeze_cycles
`endif
);

    localparam logic [CNT_W-1:0] LS_LOAD =
        (LOAD_STALL_CYCLES > 1) ? CNT_W'(LOAD_STALL_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0] MC_LOAD =
        (MC_LATENCY > 2) ? CNT_W'(MC_LATENCY - 2) : '0;

    hz_state_t        state, state_nx;
    logic             freeze, load_use, branch_acc;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt, cnt_val;

    assign freeze   = mem_access && !dmem_ready;
    assign load_use = ex_memread && (ex_rd != REG_ZERO) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));
    assign busy     = (state != RUN);

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        state_nx     = state;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        cnt_dec      = 1'b0;
        branch_acc   = 1'b0;
        if (rst) begin
            {pc_en, ifid_en, idex_en, exmem_en} = '0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (freeze) begin
            {pc_en, ifid_en, idex_en, exmem_en} = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        branch_acc = 1'b1;
                    end else if (ex_mc_start) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_bubble = 1'b1;
                        if (MC_LATENCY > 2) begin
                            cnt_load = 1'b1;
                            cnt_val  = MC_LOAD;
                            state_nx = MC_BUSY;
                        end
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            cnt_load = 1'b1;
                            cnt_val  = LS_LOAD;
                            state_nx = LOAD_STALL;
                        end
                    end
                end
                LOAD_STALL: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    if (cnt_zero) state_nx = RUN;
                    else          cnt_dec  = 1'b1;
                end
                MC_BUSY: begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_bubble = 1'b1;
                    // counter includes the current cycle here, so the op stalls MC_LATENCY-1 cycles in total
                    if (cnt <= CNT_W'(1)) state_nx = RUN;
                    if (!cnt_zero)        cnt_dec  = 1'b1;
                end
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    stall_counter #(.W(CNT_W)) u_stall_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles  <= '0;
            flush_events  <= '0;
            freeze_cycles <= '0;
        end else begin
            if (!pc_en)     stall_cycles  <= stall_cycles + 32'd1;
            if (branch_acc) flush_events  <= flush_events + 32'd1;
            if (freeze)     freeze_cycles <= freeze_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: two controller instances (default and long-stall params) against a stall-budget model.
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, ex_mc_start;
    logic       mem_access, dmem_ready;

    logic pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, ifid_flush_a, idex_flush_a, exmem_bubble_a, busy_a;
    logic pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, ifid_flush_b, idex_flush_b, exmem_bubble_b, busy_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_a, flush_a, freeze_a, stall_b, flush_b, freeze_b;
`endif

    int total = 0;
    int bad   = 0;

    int unsigned lsc [2] = '{1, 3};
    int unsigned mcl [2] = '{4, 6};
    int          m_left [2] = '{0, 0};
    bit          m_mc   [2] = '{0, 0};
    int unsigned p_stall [2] = '{0, 0};
    int unsigned p_flush [2] = '{0, 0};
    int unsigned p_freeze[2] = '{0, 0};

    always #5 clk = ~clk;

    hazard_stall_controller u_dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en_a), .ifid_en(ifid_en_a), .idex_en(idex_en_a), .exmem_en(exmem_en_a),
        .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a), .exmem_bubble(exmem_bubble_a),
        .busy(busy_a)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_a), .flush_events(flush_a), .freeze_cycles(freeze_a)
`endif
    );

    hazard_stall_controller #(.LOAD_STALL_CYCLES(3), .MC_LATENCY(6)) u_dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b), .exmem_en(exmem_en_b),
        .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b), .exmem_bubble(exmem_bubble_b),
        .busy(busy_b)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_b), .flush_events(flush_b), .freeze_cycles(freeze_b)
`endif
    );

    // Output vector order: pc, ifid, idex, exmem enables, ifid_flush, idex_flush, bubble, busy
    function automatic logic [7:0] got(int d);
        if (d == 0)
            return {pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, ifid_flush_a, idex_flush_a, exmem_bubble_a, busy_a};
        return {pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, ifid_flush_b, idex_flush_b, exmem_bubble_b, busy_b};
    endfunction

    function automatic bit hazard_load_use();
        return ex_memread && ex_rd != 5'd0 &&
               ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    endfunction

    // Model: m_left = stall cycles still owed after the one that started the hazard.
    function automatic logic [7:0] model_out(int d);
        logic b;
        b = (m_left[d] > 0);
        if (rst)                          return 8'b0000_1100;
        if (mem_access && !dmem_ready)    return {7'b0, b};
        if (m_left[d] > 0)                return m_mc[d] ? 8'b0001_0011 : 8'b0011_0101;
        if (ex_branch_taken)              return 8'b1111_1100;
        if (ex_mc_start)                  return 8'b0001_0010;
        if (hazard_load_use())            return 8'b0011_0100;
        return 8'b1111_0000;
    endfunction

    function automatic void model_advance(int d);
        if (rst) begin
            m_left[d] = 0; p_stall[d] = 0; p_flush[d] = 0; p_freeze[d] = 0;
        end else if (mem_access && !dmem_ready) begin
            p_freeze[d]++; p_stall[d]++;
        end else if (m_left[d] > 0) begin
            p_stall[d]++; m_left[d]--;
        end else if (ex_branch_taken) begin
            p_flush[d]++;
        end else if (ex_mc_start) begin
            p_stall[d]++; m_left[d] = int'(mcl[d]) - 2; m_mc[d] = 1'b1;
        end else if (hazard_load_use()) begin
            p_stall[d]++; m_left[d] = int'(lsc[d]) - 1; m_mc[d] = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_advance(0);
        model_advance(1);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
        ex_branch_taken = 1'b0; ex_mc_start = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        #2;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (got(d) !== 8'b0000_1100) begin
                bad++; $display("FAIL reset dut%0d got=%b exp=%b", d, got(d), 8'b0000_1100);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        int stalls [2];
        for (int pass = 0; pass < 2; pass++) begin
            stalls = '{0, 0};
            ex_memread = 1'b1; ex_rd = (pass == 0) ? 5'd5 : 5'd0;
            id_rs1 = ex_rd; id_use_rs1 = 1'b1;
            for (int i = 0; i < 5; i++) begin
                #2;
                for (int d = 0; d < 2; d++) begin
                    total++;
                    if (got(d) !== model_out(d)) begin
                        bad++; $display("FAIL load_use p%0d dut%0d cyc%0d got=%b exp=%b", pass, d, i, got(d), model_out(d));
                    end
                    if (got(d) [7] == 1'b0) stalls[d]++;
                end
                tick();
                idle();
            end
            for (int d = 0; d < 2; d++) begin
                total++;
                if (stalls[d] != ((pass == 0) ? int'(lsc[d]) : 0)) begin
                    bad++; $display("FAIL load_use_len p%0d dut%0d got=%0d exp=%0d", pass, d, stalls[d], (pass == 0) ? int'(lsc[d]) : 0);
                end
            end
        end
    endtask

    task automatic test_multicycle();
        int idex_off [2] = '{0, 0};
        int busy_cnt [2] = '{0, 0};
        ex_mc_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            for (int d = 0; d < 2; d++) begin
                total++;
                if (got(d) !== model_out(d)) begin
                    bad++; $display("FAIL multicycle dut%0d cyc%0d got=%b exp=%b", d, i, got(d), model_out(d));
                end
                if (got(d) [5] == 1'b0) idex_off[d]++;
                if (got(d) [0] == 1'b1) busy_cnt[d]++;
            end
            tick();
            idle();
        end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (idex_off[d] != int'(mcl[d]) - 1 || busy_cnt[d] != int'(mcl[d]) - 2) begin
                bad++; $display("FAIL multicycle_len dut%0d got=%0d/%0d exp=%0d/%0d",
                                d, idex_off[d], busy_cnt[d], mcl[d] - 1, mcl[d] - 2);
            end
        end
    endtask

    task automatic test_branch_priority();
        ex_branch_taken = 1'b1; ex_mc_start = 1'b1;
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            for (int d = 0; d < 2; d++) begin
                total++;
                if (got(d) !== model_out(d) || (i == 0 && got(d) !== 8'b1111_1100)) begin
                    bad++; $display("FAIL branch_prio dut%0d cyc%0d got=%b exp=%b", d, i, got(d), model_out(d));
                end
            end
            tick();
            idle();
        end
    endtask

    task automatic test_freeze_mid_mc();
        int stalled = 0;
        ex_mc_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #2;
            for (int d = 0; d < 2; d++) begin
                total++;
                if (got(d) !== model_out(d)) begin
                    bad++; $display("FAIL freeze dut%0d cyc%0d got=%b exp=%b", d, i, got(d), model_out(d));
                end
            end
            if (pc_en_a == 1'b0) stalled++;
            tick();
            idle();
            if (i >= 1 && i <= 3) begin
                mem_access = 1'b1; dmem_ready = 1'b0;
            end
        end
        total++;
        if (stalled != 6) begin
            bad++; $display("FAIL freeze_len got=%0d exp=%0d", stalled, 6);
        end
    endtask

    task automatic test_reset_mid_stall();
        ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
        tick();
        idle();
        #2;
        total++;
        if (busy_b !== 1'b1) begin
            bad++; $display("FAIL pre_reset_busy got=%b exp=%b", busy_b, 1'b1);
        end
        #1;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (got(d) !== 8'b0000_1100) begin
                bad++; $display("FAIL async_reset dut%0d got=%b exp=%b", d, got(d), 8'b0000_1100);
            end
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            for (int d = 0; d < 2; d++) begin
                total++;
                if (got(d) !== 8'b1111_0000) begin
                    bad++; $display("FAIL post_reset dut%0d cyc%0d got=%b exp=%b", d, i, got(d), 8'b1111_0000);
                end
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            ex_mc_start     = ($urandom_range(0, 11) == 0);
            ex_memread      = ($urandom_range(0, 2) == 0);
            ex_rd           = 5'($urandom_range(0, 3));
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom);
            id_use_rs2      = 1'($urandom);
            mem_access      = ($urandom_range(0, 5) == 0);
            dmem_ready      = 1'($urandom);
            rst             = ($urandom_range(0, 149) == 0);
            #2;
            for (int d = 0; d < 2; d++) begin
                total++;
                if (got(d) !== model_out(d)) begin
                    bad++; $display("FAIL random dut%0d cyc%0d got=%b exp=%b", d, i, got(d), model_out(d));
                end
            end
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        #2;
        total++;
        if (stall_a !== p_stall[0] || flush_a !== p_flush[0] || freeze_a !== p_freeze[0]) begin
            bad++; $display("FAIL perf dut0 got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                            stall_a, flush_a, freeze_a, p_stall[0], p_flush[0], p_freeze[0]);
        end
        total++;
        if (stall_b !== p_stall[1] || flush_b !== p_flush[1] || freeze_b !== p_freeze[1]) begin
            bad++; $display("FAIL perf dut1 got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                            stall_b, flush_b, freeze_b, p_stall[1], p_flush[1], p_freeze[1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_multicycle();
        test_branch_priority();
        test_freeze_mid_mc();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        test_reset_mid_stall();
        test_random();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
